fetch_pc_unit: RTL

- Owns the architectural program counter and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents the latched instruction and its PC to decode/execute, including the branch unit's iIR/iPC inputs.
- On each accepted instruction, consumes the execute stage's next-PC result (branch target or PC+4) and computes the next fetch address.
- Non-pipelined: at most one instruction is in flight.

---
 rtl/fetch_pc_unit_pkg.sv | 20 ++
 rtl/fetch_pc_unit_pc_next_sel.sv | 30 +++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC unit: FSM state encodings and RV32I constants.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_TRAP = 2'd3
  } fetch_state_e;

  localparam int          IR_W       = 32;
  localparam logic [31:0] RV_NOP_IR  = 32'h00000013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  // Debug helper: flags conditional-branch opcodes in a held instruction word.
  function automatic logic is_branch(input logic [IR_W-1:0] ir);
    return ir[6:0] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Next-PC selection: branch/jump target or sequential PC+4, plus redirect alignment check.
module fetch_pc_unit_pc_next_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            br_valid_i,
  input  logic [31:0]     pcbr_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] target;
  logic            unused_pcbr_hi;

  // Only the low PC_W bits of the redirect address are meaningful; the rest is dropped silently.
  assign target         = pcbr_i[PC_W-1:0];
  assign unused_pcbr_hi = &{1'b0, pcbr_i[31:PC_W]};

  always_comb begin
    next_pc_o  = pc_i + PC_W'(4);
    misalign_o = 1'b0;
    if (br_valid_i) begin
      next_pc_o  = target;
      misalign_o = (target[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Non-pipelined fetch unit: owns the PC, fetches one instruction over req/ack and holds it until execute accepts.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int               PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = 8'h00,
  parameter logic [31:0]      NOP_IR   = RV_NOP_IR
) (
  input  logic            iCLK,
  input  logic            iRST,
  output logic            oIMEM_REQ,
  output logic [PC_W-1:0] oIMEM_ADDR,
  input  logic            iIMEM_ACK,
  input  logic [31:0]     iIMEM_DATA,
  output logic [31:0]     oIR,
  output logic [PC_W-1:0] oPC,
  output logic            oIR_VALID,
  input  logic            iIR_READY,
  input  logic            iBR_VALID,
  input  logic [31:0]     iPCBR,
  output logic            oMISALIGN,
  output logic [31:0]     oRETIRED
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            req_q, req_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     retired_q, retired_d;

  logic            accept;
  logic [PC_W-1:0] next_pc;
  logic            next_misalign;

  fetch_pc_unit_pc_next_sel #(
    .PC_W (PC_W)
  ) u_pc_next_sel (
    .pc_i       (pc_q),
    .br_valid_i (iBR_VALID),
    .pcbr_i     (iPCBR),
    .next_pc_o  (next_pc),
    .misalign_o (next_misalign)
  );

  assign accept = (state_q == S_HOLD) && ir_valid_q && iIR_READY;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (iIMEM_ACK) begin
          ir_d       = iIMEM_DATA;
          ir_valid_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          retired_d  = retired_q + 32'd1;
          ir_d       = NOP_IR;
          ir_valid_d = 1'b0;
          // A misaligned redirect still retires the instruction but parks the unit; PC keeps the faulting PC.
          if (next_misalign) begin
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_IR;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  assign oIMEM_REQ  = req_q;
  assign oIMEM_ADDR = pc_q;
  assign oPC        = pc_q;
  assign oIR        = ir_q;
  assign oIR_VALID  = ir_valid_q;
  assign oMISALIGN  = misalign_q;
  assign oRETIRED   = retired_q;

endmodule
